// File: rtl/clock_set_ctrl.sv
// Purpose : run/set sequencer for the HH:MM:SS counter; 1 Hz TICK in run mode, hour->minute->second
//           BCD edit via MODE/INC pulses, commit of the edited time through a one-cycle LOAD strobe.
// Latency : every output is registered; a button pulse sampled at edge n is visible from cycle n+1.
// Backpressure: none; buttons are single-cycle pulses that are always accepted (MODE beats INC).
//
// Optional feature: define SET_TIMEOUT_EN to abort set mode (back to RUN, no LOAD) after
// TIMEOUT_CYC idle cycles. Without it the set states persist indefinitely and TIMEOUT_CYC is unused.
//
// Ports:
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   BTN_MODE, BTN_INC         debounced single-cycle button pulses
//   Hh,Hl,Mh,Ml,Sh,Sl         current time from the counter, BCD tens/units
//   TICK                      one-cycle count enable, run mode only
//   LOAD                      one-cycle strobe: counter takes SET_* values
//   SET_Hh..SET_Sl            edit-register BCD values
//   FIELD_SEL                 00 run/commit, 01 hour, 10 minute, 11 second
//   BLINK                     blink phase of the selected field, 0 outside set states

module clock_set_ctrl #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int BLINK_DIV   = 12_500_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    input  logic [3:0] Hh,
    input  logic [3:0] Hl,
    input  logic [3:0] Mh,
    input  logic [3:0] Ml,
    input  logic [3:0] Sh,
    input  logic [3:0] Sl,
    output logic       TICK,
    output logic       LOAD,
    output logic [3:0] SET_Hh,
    output logic [3:0] SET_Hl,
    output logic [3:0] SET_Mh,
    output logic [3:0] SET_Ml,
    output logic [3:0] SET_Sh,
    output logic [3:0] SET_Sl,
    output logic [1:0] FIELD_SEL,
    output logic       BLINK
);

    // Encoding chosen so that state[1:0] is exactly the FIELD_SEL code
    // (COMMIT aliases to 00), letting FIELD_SEL come straight off the state flops.
    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_SET_H  = 3'd1;
    localparam logic [2:0] ST_SET_M  = 3'd2;
    localparam logic [2:0] ST_SET_S  = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    // Parameter sanity guard; an out-of-range configuration shows up as this
    // named block in the elaborated hierarchy.
    generate
        if (CLK_DIV < 2 || BLINK_DIV < 1 || TIMEOUT_CYC < 2) begin : g_param_out_of_range
        end
    endgenerate

    logic [2:0]    state_q,  state_nx;
    logic [PW-1:0] presc_q,  presc_nx;
    logic [BW-1:0] bcnt_q,   bcnt_nx;
    logic          tick_q,   tick_nx;
    logic          load_q,   load_nx;
    logic          blink_q,  blink_nx;
    logic [3:0]    set_hh_q, set_hh_nx;
    logic [3:0]    set_hl_q, set_hl_nx;
    logic [3:0]    set_mh_q, set_mh_nx;
    logic [3:0]    set_ml_q, set_ml_nx;
    logic [3:0]    set_sh_q, set_sh_nx;
    logic [3:0]    set_sl_q, set_sl_nx;
    logic          in_set;

`ifdef SET_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] idle_q, idle_nx;
`endif

    // BCD increment with wrap. The range test uses the decimal value, so any
    // out-of-range captured value (e.g. hour 47) wraps to 00 on the first INC.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                           input logic [3:0] units,
                                           input logic [7:0] lim);
        logic [7:0] v;
        v = ({4'd0, tens} * 8'd10) + {4'd0, units};
        if (v >= lim)
            bcd_inc = 8'h00;
        else if (units == 4'd9)
            bcd_inc = {tens + 4'd1, 4'd0};
        else
            bcd_inc = {tens, units + 4'd1};
    endfunction

    assign in_set = (state_q == ST_SET_H) || (state_q == ST_SET_M) || (state_q == ST_SET_S);

    always_comb begin
        state_nx  = state_q;
        presc_nx  = presc_q;
        bcnt_nx   = bcnt_q;
        tick_nx   = 1'b0;
        load_nx   = 1'b0;
        blink_nx  = blink_q;
        set_hh_nx = set_hh_q;
        set_hl_nx = set_hl_q;
        set_mh_nx = set_mh_q;
        set_ml_nx = set_ml_q;
        set_sh_nx = set_sh_q;
        set_sl_nx = set_sl_q;

        case (state_q)
            ST_RUN: begin
                blink_nx = 1'b0;
                bcnt_nx  = '0;
                if (BTN_MODE) begin
                    // Snapshot the live time as the starting point of the edit.
                    state_nx  = ST_SET_H;
                    presc_nx  = '0;
                    blink_nx  = 1'b1;
                    set_hh_nx = Hh;
                    set_hl_nx = Hl;
                    set_mh_nx = Mh;
                    set_ml_nx = Ml;
                    set_sh_nx = Sh;
                    set_sl_nx = Sl;
                end else if (presc_q == PRESC_MAX) begin
                    presc_nx = '0;
                    tick_nx  = 1'b1;
                end else begin
                    presc_nx = presc_q + 1'b1;
                end
            end

            ST_SET_H, ST_SET_M, ST_SET_S: begin
                presc_nx = '0;
                if (BTN_MODE) begin
                    // Every field change restarts the blink phase visibly "on".
                    bcnt_nx = '0;
                    if (state_q == ST_SET_S) begin
                        state_nx = ST_COMMIT;
                        load_nx  = 1'b1;
                        blink_nx = 1'b0;
                    end else begin
                        state_nx = state_q + 3'd1;
                        blink_nx = 1'b1;
                    end
                end else begin
                    if (bcnt_q == BLINK_MAX) begin
                        bcnt_nx  = '0;
                        blink_nx = ~blink_q;
                    end else begin
                        bcnt_nx = bcnt_q + 1'b1;
                    end

                    if (BTN_INC) begin
                        case (state_q)
                            ST_SET_H: {set_hh_nx, set_hl_nx} = bcd_inc(set_hh_q, set_hl_q, 8'd23);
                            ST_SET_M: {set_mh_nx, set_ml_nx} = bcd_inc(set_mh_q, set_ml_q, 8'd59);
                            default:  {set_sh_nx, set_sl_nx} = bcd_inc(set_sh_q, set_sl_q, 8'd59);
                        endcase
                    end
`ifdef SET_TIMEOUT_EN
                    else if (idle_q == IDLE_MAX) begin
                        // Abandon the edit: no LOAD, counter keeps its own time.
                        state_nx = ST_RUN;
                        blink_nx = 1'b0;
                        bcnt_nx  = '0;
                    end
`endif
                end
            end

            ST_COMMIT: begin
                // LOAD is high during this state; SET_* are left untouched so the
                // counter sees stable values while it loads.
                state_nx = ST_RUN;
                presc_nx = '0;
                blink_nx = 1'b0;
                bcnt_nx  = '0;
            end

            default: begin
                state_nx = ST_RUN;
                presc_nx = '0;
                blink_nx = 1'b0;
                bcnt_nx  = '0;
            end
        endcase
    end

`ifdef SET_TIMEOUT_EN
    // Idle counter only advances in set states with no button activity; it is
    // zero everywhere else, which also clears it on entry to each field.
    always_comb begin
        idle_nx = '0;
        if (in_set && !BTN_MODE && !BTN_INC && (idle_q != IDLE_MAX))
            idle_nx = idle_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            idle_q <= '0;
        else
            idle_q <= idle_nx;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RUN;
            presc_q  <= '0;
            bcnt_q   <= '0;
            tick_q   <= 1'b0;
            load_q   <= 1'b0;
            blink_q  <= 1'b0;
            set_hh_q <= 4'd0;
            set_hl_q <= 4'd0;
            set_mh_q <= 4'd0;
            set_ml_q <= 4'd0;
            set_sh_q <= 4'd0;
            set_sl_q <= 4'd0;
        end else begin
            state_q  <= state_nx;
            presc_q  <= presc_nx;
            bcnt_q   <= bcnt_nx;
            tick_q   <= tick_nx;
            load_q   <= load_nx;
            blink_q  <= blink_nx;
            set_hh_q <= set_hh_nx;
            set_hl_q <= set_hl_nx;
            set_mh_q <= set_mh_nx;
            set_ml_q <= set_ml_nx;
            set_sh_q <= set_sh_nx;
            set_sl_q <= set_sl_nx;
        end
    end

    assign TICK      = tick_q;
    assign LOAD      = load_q;
    assign BLINK     = blink_q;
    assign FIELD_SEL = state_q[1:0];
    assign SET_Hh    = set_hh_q;
    assign SET_Hl    = set_hl_q;
    assign SET_Mh    = set_mh_q;
    assign SET_Ml    = set_ml_q;
    assign SET_Sh    = set_sh_q;
    assign SET_Sl    = set_sl_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Purpose : self-checking bench for clock_set_ctrl; per-cycle scoreboard against a value-level model.
// Latency : expectation for inputs driven before edge n is checked #1 after edge n.
// Backpressure: not applicable; the bench drives one input vector per cycle.

module tb_clock_set_ctrl;

    localparam int CLK_DIV     = 4;
    localparam int BLINK_DIV   = 2;
    localparam int TIMEOUT_CYC = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_MODE = 1'b0;
    logic       BTN_INC = 1'b0;
    logic [3:0] Hh = 4'd0, Hl = 4'd0, Mh = 4'd0, Ml = 4'd0, Sh = 4'd0, Sl = 4'd0;
    logic       TICK, LOAD, BLINK;
    logic [3:0] SET_Hh, SET_Hl, SET_Mh, SET_Ml, SET_Sh, SET_Sl;
    logic [1:0] FIELD_SEL;

    clock_set_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .BLINK_DIV  (BLINK_DIV),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_MODE (BTN_MODE),
        .BTN_INC  (BTN_INC),
        .Hh       (Hh),
        .Hl       (Hl),
        .Mh       (Mh),
        .Ml       (Ml),
        .Sh       (Sh),
        .Sl       (Sl),
        .TICK     (TICK),
        .LOAD     (LOAD),
        .SET_Hh   (SET_Hh),
        .SET_Hl   (SET_Hl),
        .SET_Mh   (SET_Mh),
        .SET_Ml   (SET_Ml),
        .SET_Sh   (SET_Sh),
        .SET_Sl   (SET_Sl),
        .FIELD_SEL(FIELD_SEL),
        .BLINK    (BLINK)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        tick;
        logic        load;
        logic [23:0] set;
        logic [1:0]  fsel;
        logic        blink;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: time values held as plain integers, mode as a field
    // number (0 run, 1..3 hour/min/sec, 4 commit), cycle counts since entry.
    int m_field = 0;
    int m_val[3] = '{0, 0, 0};
    int m_run   = 0;
    int m_fcnt  = 0;
    int m_idle  = 0;
    bit m_tick  = 0;
    bit m_load  = 0;
    int in_h = 0, in_m = 0, in_s = 0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic model_step(input bit rst, input bit mode, input bit inc);
        int lim;
        m_tick = 0;
        m_load = 0;
        if (rst) begin
            m_field = 0;
            m_val   = '{0, 0, 0};
            m_run   = 0;
            m_fcnt  = 0;
            m_idle  = 0;
        end else begin
            case (m_field)
                0: begin
                    if (mode) begin
                        m_val   = '{in_h, in_m, in_s};
                        m_field = 1;
                        m_fcnt  = 0;
                        m_idle  = 0;
                    end else begin
                        m_run++;
                        m_tick = (m_run % CLK_DIV) == 0;
                    end
                end
                1, 2, 3: begin
                    if (mode) begin
                        m_idle = 0;
                        m_fcnt = 0;
                        if (m_field == 3) begin
                            m_field = 4;
                            m_load  = 1;
                        end else begin
                            m_field++;
                        end
                    end else begin
                        m_fcnt++;
                        if (inc) begin
                            lim = (m_field == 1) ? 23 : 59;
                            m_val[m_field-1] = (m_val[m_field-1] >= lim) ? 0 : m_val[m_field-1] + 1;
                            m_idle = 0;
                        end
`ifdef SET_TIMEOUT_EN
                        else if (m_idle == TIMEOUT_CYC - 1) begin
                            m_field = 0;
                            m_run   = 0;
                            m_idle  = 0;
                        end else begin
                            m_idle++;
                        end
`endif
                    end
                end
                default: begin
                    m_field = 0;
                    m_run   = 0;
                end
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   setting;
        setting = (m_field >= 1) && (m_field <= 3);
        e.tick  = m_tick;
        e.load  = m_load;
        e.set   = {to_bcd(m_val[0]), to_bcd(m_val[1]), to_bcd(m_val[2])};
        e.fsel  = setting ? 2'(m_field) : 2'd0;
        e.blink = setting && (((m_fcnt / BLINK_DIV) % 2) == 0);
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic cyc(input bit rst, input bit mode, input bit inc);
        @(negedge CLK);
        RST      = rst;
        BTN_MODE = mode;
        BTN_INC  = inc;
        {Hh, Hl} = to_bcd(in_h);
        {Mh, Ml} = to_bcd(in_m);
        {Sh, Sl} = to_bcd(in_s);
        model_step(rst, mode, inc);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        in_h = h;
        in_m = m;
        in_s = s;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    exp_t mon_e;
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("tick",      int'(TICK),      int'(mon_e.tick));
            chk("load",      int'(LOAD),      int'(mon_e.load));
            chk("set_value", int'({SET_Hh, SET_Hl, SET_Mh, SET_Ml, SET_Sh, SET_Sl}), int'(mon_e.set));
            chk("field_sel", int'(FIELD_SEL), int'(mon_e.fsel));
            chk("blink",     int'(BLINK),     int'(mon_e.blink));
        end
    end

    initial begin
        // Reset for two cycles, then free-running ticks.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        idle(10);

        // Capture 12:34:56 into hour edit; ticks must stop, blink runs.
        set_time(12, 34, 56);
        cyc(0, 1, 0);
        idle(5);

        // MODE+INC together advances to minute without touching hour; reset mid-edit.
        cyc(0, 1, 1);
        idle(2);
        cyc(1, 0, 0);
        idle(3);

        // Wrap boundaries: 23 -> 00, 59 -> 00, 58 -> 59 -> 00, then commit.
        set_time(23, 59, 58);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        idle(9);

        // Minute 09 -> 10, then sit idle past the timeout window in SET_M.
        set_time(12, 9, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        idle(25);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        idle(6);

        // Out-of-range captured hour wraps to 00 on INC.
        cyc(1, 0, 0);
        set_time(47, 75, 99);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                set_time($urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99));
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0);
        end
        idle(4);

        // Every queued expectation must have been consumed by the monitor.
        @(negedge CLK);
        @(negedge CLK);
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
